// File: rtl/bitext_pkg.sv
// rtl/bitext_pkg.sv - shared types and sizing helpers for the digit-serial MSB-of-sum extractor
package bitext_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int sum_width(input int aw, input int bw);
    return (aw > bw) ? aw : bw;
  endfunction

  function automatic int ndig(input int sw, input int d);
    return (sw + d - 1) / d;
  endfunction

endpackage

// File: rtl/bitext_digit_add.sv
// rtl/bitext_digit_add.sv - one DIGIT-wide adder slice with full carry out and a tap at bit TAP
module bitext_digit_add #(
  parameter int DIGIT = 8,
  parameter int TAP   = DIGIT - 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic             cout,
  output logic             tap_y,
  output logic             tap_c
);

  logic [DIGIT-1:0] sum_unused;
  logic [TAP+1:0]   part;

  assign {cout, sum_unused} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};

  // Carry out of the tap bit differs from the slice carry when zero padding sits above it.
  assign part  = {1'b0, a[TAP:0]} + {1'b0, b[TAP:0]} + {{(TAP + 1){1'b0}}, cin};
  assign tap_y = part[TAP];
  assign tap_c = part[TAP+1];

endmodule

// File: rtl/bitext_serial.sv
// rtl/bitext_serial.sv - multi-lane digit-serial extractor of sum MSB and its carry out
module bitext_serial
  import bitext_pkg::*;
#(
  parameter int A_WIDTH  = 32,
  parameter int B_WIDTH  = 32,
  parameter int A_SIGNED = 0,
  parameter int B_SIGNED = 0,
  parameter int LANES    = 1,
  parameter int DIGIT    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*A_WIDTH-1:0]   in_a,
  input  logic [LANES*B_WIDTH-1:0]   in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES-1:0]           out_y,
  output logic [LANES-1:0]           out_cout
);

  localparam int SW   = sum_width(A_WIDTH, B_WIDTH);
  localparam int ND   = ndig(SW, DIGIT);
  localparam int PW   = ND * DIGIT;
  localparam int TAP  = (SW - 1) % DIGIT;
  localparam int CW   = (ND > 1) ? clog2(ND) : 1;
  localparam bit SEXT = (A_SIGNED != 0) && (B_SIGNED != 0);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [LANES-1:0] carry;
  logic [PW-1:0]    a_sh  [LANES];
  logic [PW-1:0]    b_sh  [LANES];
  logic [PW-1:0]    a_ext [LANES];
  logic [PW-1:0]    b_ext [LANES];
  logic [LANES-1:0] dig_cout;
  logic [LANES-1:0] tap_y;
  logic [LANES-1:0] tap_c;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [A_WIDTH-1:0] a_raw;
    logic [B_WIDTH-1:0] b_raw;
    logic [SW-1:0]      a_sw;
    logic [SW-1:0]      b_sw;

    assign a_raw = in_a[l*A_WIDTH +: A_WIDTH];
    assign b_raw = in_b[l*B_WIDTH +: B_WIDTH];

    // Sign extension only when both operands are signed, matching Verilog expression rules.
    if (SEXT) begin : g_sext
      assign a_sw = SW'($signed(a_raw));
      assign b_sw = SW'($signed(b_raw));
    end else begin : g_zext
      assign a_sw = SW'(a_raw);
      assign b_sw = SW'(b_raw);
    end

    assign a_ext[l] = PW'(a_sw);
    assign b_ext[l] = PW'(b_sw);

    bitext_digit_add #(
      .DIGIT (DIGIT),
      .TAP   (TAP)
    ) u_add (
      .a     (a_sh[l][DIGIT-1:0]),
      .b     (b_sh[l][DIGIT-1:0]),
      .cin   (carry[l]),
      .cout  (dig_cout[l]),
      .tap_y (tap_y[l]),
      .tap_c (tap_c[l])
    );
  end

  // Operands shift down one digit per RUN cycle so the adder always sees the low digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_cout  <= '0;
      for (int l = 0; l < LANES; l++) begin
        a_sh[l] <= '0;
        b_sh[l] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int l = 0; l < LANES; l++) begin
              a_sh[l] <= a_ext[l];
              b_sh[l] <= b_ext[l];
            end
            carry    <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          carry <= dig_cout;
          cnt   <= cnt + 1'b1;
          for (int l = 0; l < LANES; l++) begin
            a_sh[l] <= a_sh[l] >> DIGIT;
            b_sh[l] <= b_sh[l] >> DIGIT;
          end
          if (cnt == CW'(ND - 1)) begin
            out_y     <= tap_y;
            out_cout  <= tap_c;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
